req_arbiter: RTL and testbench

//   Arbiter/responder end of the cpu_req interface. Accepts requests from two

---
 rtl/req_arbiter.sv | 132 +++++++++++++
 tb/tb_req_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter.sv
// Round-robin arbiter between a CPU and a DMA requester in front of a single-port
// memory with fixed read latency; one access is in flight at a time.
module req_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cpu_req_valid,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic              cpu_req_rw,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_req_ack,
    output logic [DATA_W-1:0] cpu_rsp_rdata,
    input  logic              dma_req_valid,
    input  logic [ADDR_W-1:0] dma_req_addr,
    input  logic              dma_req_rw,
    input  logic [DATA_W-1:0] dma_req_wdata,
    output logic              dma_req_ack,
    output logic [DATA_W-1:0] dma_rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    // Handshake: a requester raises valid with stable fields and holds them until
    // the edge that samples its 1-cycle ack. Once granted, an access always runs to
    // completion and acks, even if valid is dropped early; only reset abandons it.

    state_t              state;
    logic                grant_dma;
    logic                last_dma;
    logic                is_write;
    logic [2:0]          cnt;

    logic                sel_dma;
    logic [ADDR_W-3:0]   sel_waddr;
    logic                sel_rw;
    logic [DATA_W-1:0]   sel_wdata;
    logic                unused_byte_addr;

    assign unused_byte_addr = ^{cpu_req_addr[1:0], dma_req_addr[1:0]};

    // DMA wins only when it is alone or when the CPU had the previous grant.
    always_comb begin
        sel_dma   = dma_req_valid && (!cpu_req_valid || !last_dma);
        sel_waddr = sel_dma ? dma_req_addr[ADDR_W-1:2] : cpu_req_addr[ADDR_W-1:2];
        sel_rw    = sel_dma ? dma_req_rw : cpu_req_rw;
        sel_wdata = sel_dma ? dma_req_wdata : cpu_req_wdata;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            grant_dma     <= 1'b0;
            last_dma      <= 1'b1;
            is_write      <= 1'b0;
            cnt           <= 3'd0;
            cpu_req_ack   <= 1'b0;
            dma_req_ack   <= 1'b0;
            cpu_rsp_rdata <= '0;
            dma_rsp_rdata <= '0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_valid || dma_req_valid) begin
                        grant_dma <= sel_dma;
                        last_dma  <= sel_dma;
                        is_write  <= sel_rw;
                        mem_addr  <= sel_waddr;
                        mem_wdata <= sel_wdata;
                        mem_we    <= sel_rw;
                        mem_en    <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (is_write) begin
                        cpu_req_ack <= !grant_dma;
                        dma_req_ack <= grant_dma;
                        state       <= RESP;
                    end else begin
                        cnt   <= 3'd1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == LAT) begin
                        if (grant_dma) begin
                            dma_rsp_rdata <= mem_rdata;
                        end else begin
                            cpu_rsp_rdata <= mem_rdata;
                        end
                        cpu_req_ack <= !grant_dma;
                        dma_req_ack <= grant_dma;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RESP: begin
                    cpu_req_ack <= 1'b0;
                    dma_req_ack <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_req_arbiter.sv
// Self-checking bench for req_arbiter: one instance at MEM_LAT=1 (CPU and DMA),
// one at MEM_LAT=3 (DMA only), each with a latency-accurate memory model.
module tb_req_arbiter;
    localparam int AW = 23;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cpu_req_valid, cpu_req_rw, cpu_req_ack;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_wdata, cpu_rsp_rdata;
    logic          dma_req_valid, dma_req_rw, dma_req_ack;
    logic [AW-1:0] dma_req_addr;
    logic [DW-1:0] dma_req_wdata, dma_rsp_rdata;
    logic          mem_en, mem_we;
    logic [AW-3:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    dbg_state;

    logic          d3_valid, d3_rw, d3_ack, c3_ack;
    logic [AW-1:0] d3_addr;
    logic [DW-1:0] d3_wdata, d3_rdata, c3_rdata;
    logic          mem_en3, mem_we3;
    logic [AW-3:0] mem_addr3;
    logic [DW-1:0] mem_wdata3, mem_rdata3;
    logic [1:0]    dbg3;

    req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_rw(cpu_req_rw),
        .cpu_req_wdata(cpu_req_wdata), .cpu_req_ack(cpu_req_ack), .cpu_rsp_rdata(cpu_rsp_rdata),
        .dma_req_valid(dma_req_valid), .dma_req_addr(dma_req_addr), .dma_req_rw(dma_req_rw),
        .dma_req_wdata(dma_req_wdata), .dma_req_ack(dma_req_ack), .dma_rsp_rdata(dma_rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cpu_req_valid(1'b0), .cpu_req_addr('0), .cpu_req_rw(1'b0),
        .cpu_req_wdata('0), .cpu_req_ack(c3_ack), .cpu_rsp_rdata(c3_rdata),
        .dma_req_valid(d3_valid), .dma_req_addr(d3_addr), .dma_req_rw(d3_rw),
        .dma_req_wdata(d3_wdata), .dma_req_ack(d3_ack), .dma_rsp_rdata(d3_rdata),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .dbg_state(dbg3)
    );

    // Memory models: read data is valid exactly LAT cycles after mem_en, garbage otherwise.
    logic [DW-1:0] rd_val1, rd_val3, p1_d;
    logic          p1_v;
    logic [2:0]    p3_v;
    logic [DW-1:0] p3_d [3];

    always @(posedge clk) begin
        if (rst) begin
            p1_v <= 1'b0;
            p3_v <= 3'b000;
        end else begin
            p1_v <= mem_en && !mem_we;
            p3_v <= {p3_v[1:0], mem_en3 && !mem_we3};
        end
        p1_d    <= rd_val1;
        p3_d[0] <= rd_val3;
        p3_d[1] <= p3_d[0];
        p3_d[2] <= p3_d[1];
    end
    assign mem_rdata  = p1_v    ? p1_d    : 32'hBAD1_BAD1;
    assign mem_rdata3 = p3_v[2] ? p3_d[2] : 32'hBAD3_BAD3;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW:0]   exp_q [$];
    logic [7:0]    grant_q [$];
    logic [DW-1:0] exp_cpu_rsp, exp_dma_rsp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic dma, input logic [AW-1:0] addr, input logic rw,
                             input logic [DW-1:0] wd);
        if (dma) begin
            dma_req_valid = 1'b1; dma_req_addr = addr; dma_req_rw = rw; dma_req_wdata = wd;
        end else begin
            cpu_req_valid = 1'b1; cpu_req_addr = addr; cpu_req_rw = rw; cpu_req_wdata = wd;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_req_valid = 0; cpu_req_addr = '0; cpu_req_rw = 0; cpu_req_wdata = '0;
        dma_req_valid = 0; dma_req_addr = '0; dma_req_rw = 0; dma_req_wdata = '0;
        d3_valid = 0; d3_addr = '0; d3_rw = 0; d3_wdata = '0;
        rd_val1 = '0; rd_val3 = '0;
        tick(); tick();
        n_cmp++;
        if ({cpu_req_ack, dma_req_ack, mem_en, mem_we} !== 4'b0000) begin
            n_err++; $display("FAIL reset_strobes: got %b want 0000", {cpu_req_ack, dma_req_ack, mem_en, mem_we});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== '0) begin
            n_err++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        n_cmp++;
        if ({cpu_rsp_rdata, dma_rsp_rdata} !== '0) begin
            n_err++; $display("FAIL reset_rsp: got %h/%h want 0/0", cpu_rsp_rdata, dma_rsp_rdata);
        end
        n_cmp++;
        if (dbg_state !== 2'd0) begin
            n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        n_cmp++;
        if ({c3_ack, d3_ack, mem_en3, mem_we3, mem_addr3, mem_wdata3, c3_rdata, d3_rdata, dbg3} !== '0) begin
            n_err++; $display("FAIL reset_lat3: got nonzero outputs want all 0");
        end
        rst = 1'b0;
        exp_cpu_rsp = '0;
        exp_dma_rsp = '0;
        tick();
    endtask

    task automatic test_single_read();
        int n;
        logic [DW:0] e;
        rd_val1 = 32'hDEAD_BEEF;
        exp_cpu_rsp = 32'hDEAD_BEEF;
        exp_q.push_back({1'b0, exp_cpu_rsp});
        drive_req(1'b0, 23'h10, 1'b0, '0);
        tick();
        n_cmp++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, 21'h4}) begin
            n_err++; $display("FAIL read_issue: got en=%b we=%b addr=%h want 1/0/4", mem_en, mem_we, mem_addr);
        end
        n = 1;
        while (!cpu_req_ack && n < 20) begin tick(); n++; end
        n_cmp++;
        if (n !== 3) begin
            n_err++; $display("FAIL read_latency: got %0d want 3", n);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({dma_req_ack, cpu_rsp_rdata} !== {e[DW], e[DW-1:0]}) begin
            n_err++; $display("FAIL read_data: got dma_ack=%b rdata=%h want %b/%h", dma_req_ack, cpu_rsp_rdata, e[DW], e[DW-1:0]);
        end
        cpu_req_valid = 1'b0;
        tick();
        n_cmp++;
        if (cpu_req_ack !== 1'b0) begin
            n_err++; $display("FAIL read_ack_pulse: got %b want 0", cpu_req_ack);
        end
    endtask

    task automatic test_single_write();
        logic [DW:0] e;
        logic dma_seen;
        exp_q.push_back({1'b0, exp_cpu_rsp});
        drive_req(1'b0, 23'h20, 1'b1, 32'h1234_5678);
        tick();
        dma_seen = dma_req_ack;
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 21'h8, 32'h1234_5678}) begin
            n_err++; $display("FAIL write_issue: got en=%b we=%b addr=%h wd=%h want 1/1/8/12345678", mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        dma_seen = dma_seen | dma_req_ack;
        e = exp_q.pop_front();
        n_cmp++;
        if ({cpu_req_ack, cpu_rsp_rdata} !== {1'b1, e[DW-1:0]}) begin
            n_err++; $display("FAIL write_ack: got ack=%b rsp=%h want 1/%h", cpu_req_ack, cpu_rsp_rdata, e[DW-1:0]);
        end
        n_cmp++;
        if (dma_seen !== 1'b0) begin
            n_err++; $display("FAIL write_dma_quiet: got %b want 0", dma_seen);
        end
        cpu_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] g;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cpu_rsp = '0;
        exp_dma_rsp = '0;
        grant_q = {8'h02, 8'h85, 8'h08, 8'h8B};
        drive_req(1'b0, 23'h100, 1'b1, 32'h1111_0000);
        drive_req(1'b1, 23'h200, 1'b1, 32'h2222_0000);
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (mem_en && grant_q.size() > 0) begin
                n_cmp++;
                if (mem_wdata !== (grant_q[0][7] ? 32'h2222_0000 : 32'h1111_0000)) begin
                    n_err++; $display("FAIL rr_wdata: cycle %0d got %h", c, mem_wdata);
                end
            end
            if (cpu_req_ack || dma_req_ack) begin
                n_cmp++;
                if (grant_q.size() == 0) begin
                    n_err++; $display("FAIL rr_extra_ack: cycle %0d got ack want none", c);
                end else begin
                    g = grant_q.pop_front();
                    if ({dma_req_ack, cpu_req_ack, 7'(c)} !== {g[7], ~g[7], g[6:0]}) begin
                        n_err++; $display("FAIL rr_grant: got dma=%b cpu=%b cyc=%0d want dma=%b cyc=%0d",
                                          dma_req_ack, cpu_req_ack, c, g[7], g[6:0]);
                    end
                end
            end
        end
        n_cmp++;
        if (grant_q.size() !== 0) begin
            n_err++; $display("FAIL rr_missing_acks: got %0d pending want 0", grant_q.size());
        end
        grant_q.delete();
        cpu_req_valid = 1'b0;
        dma_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_dma_lat3();
        int n;
        logic [DW:0] e;
        rd_val3 = 32'hA5A5_A5A5;
        exp_q.push_back({1'b1, 32'hA5A5_A5A5});
        d3_valid = 1'b1; d3_addr = 23'h40; d3_rw = 1'b0; d3_wdata = '0;
        tick();
        n_cmp++;
        if ({mem_en3, mem_we3, mem_addr3} !== {2'b10, 21'h10}) begin
            n_err++; $display("FAIL lat3_issue: got en=%b we=%b addr=%h want 1/0/10", mem_en3, mem_we3, mem_addr3);
        end
        n = 1;
        while (!d3_ack && n < 20) begin tick(); n++; end
        n_cmp++;
        if (n !== 5) begin
            n_err++; $display("FAIL lat3_latency: got %0d want 5", n);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({c3_ack, d3_rdata} !== {1'b0, e[DW-1:0]}) begin
            n_err++; $display("FAIL lat3_data: got cpu_ack=%b rdata=%h want 0/%h", c3_ack, d3_rdata, e[DW-1:0]);
        end
        d3_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        logic [DW:0] e;
        drive_req(1'b0, 23'h44, 1'b1, 32'hCAFE_0001);
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({mem_en, mem_we, cpu_req_ack} !== 3'b000) begin
            n_err++; $display("FAIL rst_access: got en=%b we=%b ack=%b want 000", mem_en, mem_we, cpu_req_ack);
        end
        rst = 1'b0;
        cpu_req_valid = 1'b0;
        tick();
        rd_val1 = 32'h0BAD_F00D;
        drive_req(1'b0, 23'h30, 1'b0, '0);
        tick(); tick();
        n_cmp++;
        if (dbg_state !== 2'd2) begin
            n_err++; $display("FAIL rst_wait_state: got %0d want 2", dbg_state);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({cpu_req_ack, dma_req_ack, mem_en, mem_we, mem_addr, mem_wdata, cpu_rsp_rdata, dbg_state} !== '0) begin
            n_err++; $display("FAIL rst_wait_outputs: got ack=%b en=%b addr=%h rsp=%h st=%0d want all 0",
                              cpu_req_ack, mem_en, mem_addr, cpu_rsp_rdata, dbg_state);
        end
        rst = 1'b0;
        cpu_req_addr = 23'h80;
        rd_val1 = 32'h600D_CAFE;
        exp_cpu_rsp = 32'h600D_CAFE;
        exp_dma_rsp = '0;
        exp_q.push_back({1'b0, exp_cpu_rsp});
        n = 0;
        while (!cpu_req_ack && n < 20) begin tick(); n++; end
        n_cmp++;
        if (n !== 3) begin
            n_err++; $display("FAIL rst_next_latency: got %0d want 3", n);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (cpu_rsp_rdata !== e[DW-1:0]) begin
            n_err++; $display("FAIL rst_next_data: got %h want %h", cpu_rsp_rdata, e[DW-1:0]);
        end
        cpu_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_drop_valid();
        int n;
        logic [DW:0] e;
        int acks;
        rd_val1 = 32'h1357_9BDF;
        exp_cpu_rsp = 32'h1357_9BDF;
        exp_q.push_back({1'b0, exp_cpu_rsp});
        drive_req(1'b0, 23'h24, 1'b0, '0);
        tick();
        cpu_req_valid = 1'b0;
        cpu_req_addr = 23'h7FFFFC;
        n = 1;
        while (!cpu_req_ack && n < 20) begin tick(); n++; end
        n_cmp++;
        if (n !== 3) begin
            n_err++; $display("FAIL drop_latency: got %0d want 3", n);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (cpu_rsp_rdata !== e[DW-1:0]) begin
            n_err++; $display("FAIL drop_data: got %h want %h", cpu_rsp_rdata, e[DW-1:0]);
        end
        tick();
        n_cmp++;
        if ({cpu_req_ack, dbg_state} !== 3'b000) begin
            n_err++; $display("FAIL drop_idle: got ack=%b st=%0d want 0/0", cpu_req_ack, dbg_state);
        end
        acks = 0;
        for (int i = 0; i < 4; i++) begin tick(); acks += int'(cpu_req_ack); end
        n_cmp++;
        if (acks !== 0) begin
            n_err++; $display("FAIL drop_single_pulse: got %0d extra acks want 0", acks);
        end
    endtask

    task automatic test_random_mix();
        int n;
        logic [DW:0] e;
        logic dma, rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        for (int i = 0; i < 10; i++) begin
            dma  = 1'($urandom_range(0, 1));
            rw   = 1'($urandom_range(0, 1));
            addr = {13'd0, 8'($urandom_range(0, 255)), 2'b00};
            wd   = $urandom;
            rd_val1 = $urandom;
            if (!rw) begin
                if (dma) exp_dma_rsp = rd_val1; else exp_cpu_rsp = rd_val1;
            end
            exp_q.push_back({dma, dma ? exp_dma_rsp : exp_cpu_rsp});
            drive_req(dma, addr, rw, wd);
            tick();
            n_cmp++;
            if ({mem_en, mem_we, mem_addr} !== {1'b1, rw, addr[AW-1:2]} || (rw && mem_wdata !== wd)) begin
                n_err++; $display("FAIL rand_issue[%0d]: got en=%b we=%b addr=%h wd=%h want 1/%b/%h/%h",
                                  i, mem_en, mem_we, mem_addr, mem_wdata, rw, addr[AW-1:2], wd);
            end
            n = 1;
            while (!(cpu_req_ack || dma_req_ack) && n < 20) begin tick(); n++; end
            e = exp_q.pop_front();
            n_cmp++;
            if ({n, dma_req_ack, cpu_req_ack} !== {(rw ? 2 : 3), e[DW], ~e[DW]}) begin
                n_err++; $display("FAIL rand_ack[%0d]: got lat=%0d dma=%b cpu=%b want lat=%0d dma=%b",
                                  i, n, dma_req_ack, cpu_req_ack, (rw ? 2 : 3), e[DW]);
            end
            n_cmp++;
            if ({cpu_rsp_rdata, dma_rsp_rdata} !== (e[DW] ? {exp_cpu_rsp, e[DW-1:0]} : {e[DW-1:0], exp_dma_rsp})) begin
                n_err++; $display("FAIL rand_rsp[%0d]: got cpu=%h dma=%h want cpu=%h dma=%h",
                                  i, cpu_rsp_rdata, dma_rsp_rdata, exp_cpu_rsp, exp_dma_rsp);
            end
            cpu_req_valid = 1'b0;
            dma_req_valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_dma_lat3();
        test_reset_mid();
        test_drop_valid();
        test_random_mix();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
